cache: RTL and testbench

Direct-mapped, write-back, write-allocate data cache between the CPU data bus (`db_*`) and the main-memory bus (`dbOut_*`). The set index comes from the virtual address and the tag from the physical address, so the lookup is virtually indexed and physically tagged. Hits complete in zero wait states. Misses write back a dirty victim line, then fill the line one word at a time.

---
 rtl/cache.sv | 188 ++++++++++++++++++
 tb/tb_cache.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache.sv
// cache: direct-mapped, write-back, write-allocate data cache, virtually indexed / physically tagged.
// Defining CACHE_UNCACHED_EN adds a single-word bypass path for accesses with cachable = 0.
module cache #(
    parameter int unsigned INBLOCK_ADDR_WIDTH = 4,
    parameter int unsigned INDEX_WIDTH        = 4
) (
    input  logic        clk,
    input  logic        res,
    output logic        ready,
    input  logic        cachable,
    input  logic [31:0] pAddr,
    input  logic [31:0] vAddr,
    input  logic [31:0] db_dataOut,
    output logic [31:0] db_dataIn,
    input  logic [1:0]  db_accessType,
    output logic        db_ready,
    input  logic [31:0] dbOut_dataIn,
    input  logic        dbOut_ready,
    output logic [31:0] dbOut_addr,
    output logic [31:0] dbOut_dataOut,
    output logic        dbOut_re,
    output logic        dbOut_we
);
    localparam int unsigned WORD_W = INBLOCK_ADDR_WIDTH - 2;
    localparam int unsigned WORDS  = 1 << WORD_W;
    localparam int unsigned LINES  = 1 << INDEX_WIDTH;
    localparam int unsigned TAG_W  = 32 - INDEX_WIDTH - INBLOCK_ADDR_WIDTH;

    localparam logic [1:0] MEM_ACCESS_R = 2'd1;
    localparam logic [1:0] MEM_ACCESS_W = 2'd2;

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_WB, S_FILL_REQ, S_FILL_DATA, S_UNC
    } state_e;

    state_e                   state_q;
    logic [INDEX_WIDTH-1:0]   line_q;
    logic [WORD_W-1:0]        word_q;
    logic                     valid_q [LINES];
    logic                     dirty_q [LINES];
    logic [TAG_W-1:0]         tag_q   [LINES];
    logic [31:0]              data_q  [LINES][WORDS];
`ifdef CACHE_UNCACHED_EN
    logic                     unc_phase_q;
`endif

    logic [INDEX_WIDTH-1:0] idx;
    logic [WORD_W-1:0]      wsel;
    logic [TAG_W-1:0]       ptag;
    logic                   is_rd, is_wr, is_acc, hit, unc_req;
    logic                   unused_bits;

    assign idx    = vAddr[INBLOCK_ADDR_WIDTH +: INDEX_WIDTH];
    assign wsel   = vAddr[2 +: WORD_W];
    assign ptag   = pAddr[31 -: TAG_W];
    assign is_rd  = (db_accessType == MEM_ACCESS_R);
    assign is_wr  = (db_accessType == MEM_ACCESS_W);
    assign is_acc = is_rd || is_wr;
    assign hit    = valid_q[idx] && (tag_q[idx] == ptag);
`ifdef CACHE_UNCACHED_EN
    assign unc_req = is_acc && !cachable;
`else
    assign unc_req = 1'b0;
`endif
    assign unused_bits = ^{cachable, pAddr, vAddr};

    // Output decode: hits answer combinationally, bus strobes follow the registered state.
    always_comb begin
        ready         = (state_q != S_INIT);
        db_ready      = 1'b0;
        db_dataIn     = '0;
        dbOut_addr    = '0;
        dbOut_dataOut = '0;
        dbOut_re      = 1'b0;
        dbOut_we      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!is_acc) begin
                    db_ready = 1'b1;
                end else if (!unc_req && hit) begin
                    db_ready = 1'b1;
                    if (is_rd) db_dataIn = data_q[idx][wsel];
                end
            end
            S_WB: begin
                dbOut_we      = 1'b1;
                dbOut_addr    = {tag_q[idx], idx, word_q, 2'b00};
                dbOut_dataOut = data_q[idx][word_q];
            end
            S_FILL_REQ: begin
                dbOut_re   = 1'b1;
                dbOut_addr = {ptag, idx, word_q, 2'b00};
            end
`ifdef CACHE_UNCACHED_EN
            S_UNC: begin
                if (!unc_phase_q) begin
                    dbOut_re   = is_rd;
                    dbOut_we   = is_wr;
                    dbOut_addr = {pAddr[31:2], 2'b00};
                    if (is_wr) begin
                        dbOut_dataOut = db_dataOut;
                        db_ready      = dbOut_ready;
                    end
                end else begin
                    db_ready  = 1'b1;
                    db_dataIn = dbOut_dataIn;
                end
            end
`endif
            default: ;
        endcase
    end

    // Controller and line storage; a miss leaves the CPU access pending until the line is resident.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= S_INIT;
            line_q  <= '0;
            word_q  <= '0;
`ifdef CACHE_UNCACHED_EN
            unc_phase_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_INIT: begin
                    valid_q[line_q] <= 1'b0;
                    dirty_q[line_q] <= 1'b0;
                    line_q          <= line_q + INDEX_WIDTH'(1);
                    if (&line_q) state_q <= S_IDLE;
                end
                S_IDLE: begin
                    word_q <= '0;
                    if (is_acc) begin
                        if (unc_req) begin
                            state_q <= S_UNC;
                        end else if (hit) begin
                            if (is_wr) begin
                                data_q[idx][wsel] <= db_dataOut;
                                dirty_q[idx]      <= 1'b1;
                            end
                        end else if (valid_q[idx] && dirty_q[idx]) begin
                            state_q <= S_WB;
                        end else begin
                            state_q <= S_FILL_REQ;
                        end
                    end
                end
                S_WB: begin
                    if (dbOut_ready) begin
                        word_q <= word_q + WORD_W'(1);
                        if (&word_q) begin
                            dirty_q[idx] <= 1'b0;
                            state_q      <= S_FILL_REQ;
                        end
                    end
                end
                S_FILL_REQ: begin
                    if (dbOut_ready) state_q <= S_FILL_DATA;
                end
                S_FILL_DATA: begin
                    data_q[idx][word_q] <= dbOut_dataIn;
                    word_q              <= word_q + WORD_W'(1);
                    if (&word_q) begin
                        valid_q[idx] <= 1'b1;
                        tag_q[idx]   <= ptag;
                        state_q      <= S_IDLE;
                    end else begin
                        state_q <= S_FILL_REQ;
                    end
                end
`ifdef CACHE_UNCACHED_EN
                S_UNC: begin
                    if (!unc_phase_q) begin
                        if (dbOut_ready) begin
                            if (is_rd) unc_phase_q <= 1'b1;
                            else       state_q     <= S_IDLE;
                        end
                    end else begin
                        unc_phase_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
`endif
                default: state_q <= S_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_cache.sv
// tb_cache: directed vector table, hand-written reset/stall/uncached sequences and a
// randomized run checked against a flat-memory reference model of CPU-visible data.
module tb_cache;
    localparam logic [1:0] AC_NONE = 2'd0;
    localparam logic [1:0] AC_R    = 2'd1;
    localparam logic [1:0] AC_W    = 2'd2;
    localparam int         MAXW    = 200;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        cachable = 1'b1;
    logic [31:0] pAddr = '0, vAddr = '0, db_dataOut = '0;
    logic [1:0]  db_accessType = AC_NONE;
    logic        ready, db_ready, dbOut_re, dbOut_we;
    logic [31:0] db_dataIn, dbOut_addr, dbOut_dataOut;
    logic [31:0] dbOut_dataIn = '0;
    logic        dbOut_ready;
    logic        rdy_hold = 1'b1;
    logic        rnd_rdy = 1'b1;
    bit          rnd_en = 1'b0;
    bit          mem_load = 1'b1;

    logic [31:0] mem [1024];
    logic [31:0] ref_mem [1024];

    typedef struct { bit we; logic [31:0] addr; logic [31:0] data; } ev_t;
    ev_t ev_q[$];
    int  both_cnt = 0;

    int n_cmp = 0;
    int n_bad = 0;

    assign dbOut_ready = rdy_hold & rnd_rdy;

    always #5 clk = ~clk;

    cache dut (
        .clk(clk), .res(res), .ready(ready), .cachable(cachable),
        .pAddr(pAddr), .vAddr(vAddr), .db_dataOut(db_dataOut), .db_dataIn(db_dataIn),
        .db_accessType(db_accessType), .db_ready(db_ready),
        .dbOut_dataIn(dbOut_dataIn), .dbOut_ready(dbOut_ready), .dbOut_addr(dbOut_addr),
        .dbOut_dataOut(dbOut_dataOut), .dbOut_re(dbOut_re), .dbOut_we(dbOut_we)
    );

    // Main memory: one-cycle read latency, accepts a transfer when dbOut_ready is high.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            mem[0]  <= 32'h02030405;
            mem[1]  <= 32'h06070809;
            mem[64] <= 32'h0badcafe;
            mem[65] <= 32'h03030303;
        end else if (dbOut_ready) begin
            if (dbOut_re) dbOut_dataIn <= mem[dbOut_addr[11:2]];
            if (dbOut_we) mem[dbOut_addr[11:2]] <= dbOut_dataOut;
        end
    end

    // Bus monitor: logs every accepted transfer.
    always @(posedge clk) begin
        if (dbOut_re && dbOut_we) both_cnt <= both_cnt + 1;
        if (dbOut_ready && !res && (dbOut_re || dbOut_we))
            ev_q.push_back('{we: dbOut_we, addr: dbOut_addr, data: dbOut_dataOut});
    end

    always @(posedge clk) rnd_rdy <= rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        int n;
        res = 1'b1;
        mem_load = 1'b1;
        repeat (2) @(posedge clk);
        #1 res = 1'b0;
        mem_load = 1'b0;
        n = 0;
        while (!ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
    endtask

    // One CPU access; waits = cycles without db_ready before completion.
    task automatic access(input logic [1:0] kind, input logic [31:0] pa, input logic [31:0] va,
                          input logic [31:0] wd, output logic [31:0] rd, output int waits);
        pAddr = pa;
        vAddr = va;
        db_dataOut = wd;
        db_accessType = kind;
        waits = 0;
        rd = 'x;
        forever begin
            @(negedge clk);
            if (db_ready) begin
                rd = db_dataIn;
                break;
            end
            waits++;
            if (waits > MAXW) begin
                chk("access_timeout", 32'(waits), 32'(MAXW));
                break;
            end
        end
        @(posedge clk);
        #1 db_accessType = AC_NONE;
    endtask

    typedef struct {
        bit          rst;
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] wd;
        bit          chk_rd;
        logic [31:0] rd;
        int          waits;
        int          n_re;
        int          n_we;
        logic [31:0] re_a0;
        logic [31:0] wb_a0;
        logic [31:0] wb_d0;
        logic [31:0] wb_d1;
    } vec_t;

    initial begin
        vec_t        vecs[$];
        logic [31:0] rd;
        int          waits, st, nre, nwe, low_cnt, last_we, first_re;
        bit          traffic;

        // Reset values and INIT duration
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_db_ready", 32'(db_ready), 32'h0);
        chk("rst_re", 32'(dbOut_re), 32'h0);
        chk("rst_we", 32'(dbOut_we), 32'h0);
        chk("rst_addr", dbOut_addr, 32'h0);
        chk("rst_wdata", dbOut_dataOut, 32'h0);
        chk("rst_rdata", db_dataIn, 32'h0);
        @(posedge clk);
        #1 res = 1'b0;
        mem_load = 1'b0;
        low_cnt = 0;
        traffic = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dbOut_re || dbOut_we) traffic = 1'b1;
            if (ready) break;
            low_cnt++;
        end
        chk("init_cycles", 32'(low_cnt), 32'd16);
        chk("init_traffic", 32'(traffic), 32'h0);
        @(posedge clk);
        #1;

        vecs.push_back('{0, AC_R, 32'h000, 32'h0, 1, 32'h02030405, 9, 4, 0, 32'h000, 32'h0, 32'h0, 32'h0});
        vecs.push_back('{0, AC_R, 32'h004, 32'h0, 1, 32'h06070809, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0});
        vecs.push_back('{0, AC_NONE, 32'h004, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0});
        vecs.push_back('{0, 2'd3, 32'h300, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0});
        vecs.push_back('{1, AC_W, 32'h000, 32'h0badc0de, 0, 32'h0, 9, 4, 0, 32'h000, 32'h0, 32'h0, 32'h0});
        vecs.push_back('{0, AC_R, 32'h000, 32'h0, 1, 32'h0badc0de, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0});
        vecs.push_back('{0, AC_W, 32'h100, 32'hdeadbeef, 0, 32'h0, 13, 4, 4, 32'h100, 32'h000, 32'h0badc0de, 32'h06070809});
        vecs.push_back('{0, AC_R, 32'h200, 32'h0, 1, 32'h0, 13, 4, 4, 32'h200, 32'h100, 32'hdeadbeef, 32'h03030303});
        vecs.push_back('{0, AC_R, 32'h100, 32'h0, 1, 32'hdeadbeef, 9, 4, 0, 32'h100, 32'h0, 32'h0, 32'h0});

        foreach (vecs[v]) begin
            if (vecs[v].rst) do_reset();
            st = ev_q.size();
            access(vecs[v].kind, vecs[v].addr, vecs[v].addr ^ 32'h5a5a0000, vecs[v].wd, rd, waits);
            if (vecs[v].chk_rd) chk($sformatf("v%0d_rdata", v), rd, vecs[v].rd);
            chk($sformatf("v%0d_waits", v), 32'(waits), 32'(vecs[v].waits));
            nre = 0;
            nwe = 0;
            last_we = -1;
            first_re = 1 << 30;
            for (int e = st; e < ev_q.size(); e++) begin
                if (ev_q[e].we) begin
                    chk($sformatf("v%0d_wb_addr", v), ev_q[e].addr, vecs[v].wb_a0 + 32'(4 * nwe));
                    if (nwe == 0) chk($sformatf("v%0d_wb_d0", v), ev_q[e].data, vecs[v].wb_d0);
                    if (nwe == 1) chk($sformatf("v%0d_wb_d1", v), ev_q[e].data, vecs[v].wb_d1);
                    nwe++;
                    last_we = e;
                end else begin
                    chk($sformatf("v%0d_fill_addr", v), ev_q[e].addr, vecs[v].re_a0 + 32'(4 * nre));
                    if (nre == 0) first_re = e;
                    nre++;
                end
            end
            chk($sformatf("v%0d_n_re", v), 32'(nre), 32'(vecs[v].n_re));
            chk($sformatf("v%0d_n_we", v), 32'(nwe), 32'(vecs[v].n_we));
            if (nwe > 0) chk($sformatf("v%0d_wb_first", v), 32'(last_we < first_re), 32'h1);
        end

        // Stall three cycles on the first fill request
        do_reset();
        st = ev_q.size();
        fork
            access(AC_R, 32'h000, 32'h000, 32'h0, rd, waits);
            begin
                int n;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!dbOut_re && n < 50);
                chk("stall_seen_re", 32'(dbOut_re), 32'h1);
                rdy_hold = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk($sformatf("stall_re_%0d", i), 32'(dbOut_re), 32'h1);
                    chk($sformatf("stall_addr_%0d", i), dbOut_addr, 32'h000);
                end
                rdy_hold = 1'b1;
            end
        join
        chk("stall_rdata", rd, 32'h02030405);
        chk("stall_waits", 32'(waits), 32'd12);
        chk("stall_n_ev", 32'(ev_q.size() - st), 32'd4);

`ifdef CACHE_UNCACHED_EN
        do_reset();
        cachable = 1'b0;
        st = ev_q.size();
        access(AC_R, 32'h100, 32'h100, 32'h0, rd, waits);
        chk("unc_rdata", rd, 32'h0badcafe);
        chk("unc_n_ev", 32'(ev_q.size() - st), 32'd1);
        if (ev_q.size() > st) chk("unc_is_read", 32'(ev_q[st].we), 32'h0);
        cachable = 1'b1;
        access(AC_R, 32'h100, 32'h100, 32'h0, rd, waits);
        chk("unc_then_miss_waits", 32'(waits), 32'd9);
        chk("unc_then_miss_rdata", rd, 32'h0badcafe);
`endif

        // Randomized traffic with random memory stalls against a flat memory model
        do_reset();
        for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
        rnd_en = 1'b1;
        for (int t = 0; t < 300; t++) begin
            logic [31:0] pa, va, wd;
            logic [1:0]  kind;
            int          k;
            pa = {22'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'b00};
            va = {$urandom_range(0, 32'hffffff) & 32'h00ffffff, pa[7:0]} ;
            wd = $urandom;
            k = $urandom_range(0, 9);
            kind = (k < 5) ? AC_R : (k < 9) ? AC_W : AC_NONE;
            access(kind, pa, va, wd, rd, waits);
            if (kind == AC_R) chk($sformatf("rnd%0d_rdata@%h", t, pa), rd, ref_mem[pa[11:2]]);
            if (kind == AC_W) ref_mem[pa[11:2]] = wd;
        end
        rnd_en = 1'b0;
        chk("re_we_exclusive", 32'(both_cnt), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
